// File: rtl/sam_pkg.sv
// Shared token encoding and helpers for SAM-style sparse stream blocks.
// A stream word is DATA_W+1 bits; the top bit marks a control token.
package sam_pkg;

  localparam int DATA_W   = 16;
  localparam int FLAG_BIT = DATA_W;

  localparam logic [DATA_W-1:0] DONE_TOKEN  = 16'h0100;
  localparam logic [DATA_W-1:0] MAYBE_TOKEN = 16'h0200;

  typedef enum logic {
    JOIN_INTERSECT = 1'b0,
    JOIN_UNION     = 1'b1
  } joiner_op_t;

  typedef enum logic {
    ST_START = 1'b0,
    ST_RUN   = 1'b1
  } join_state_t;

  function automatic logic is_done(input logic [DATA_W:0] word);
    return word[FLAG_BIT] && (word[DATA_W-1:0] == DONE_TOKEN);
  endfunction

  function automatic logic is_stop(input logic [DATA_W:0] word);
    return word[FLAG_BIT] && (word[DATA_W-1:0] < DATA_W'(16));
  endfunction

endpackage

// File: rtl/reg_fifo.sv
// Small registered valid/ready FIFO; empty output reads as zero.
// Ready depends only on occupancy, so it never combinationally follows valid.
module reg_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = clk_en && in_valid && in_ready;
  assign pop       = clk_en && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/intersect_unit.sv
// Two-stream coordinate joiner (intersect/union) with paired position streams.
// Inputs and outputs are buffered; the join decision is combinational between them.
module intersect_unit #(
  parameter int DATA_W = 16,
  parameter int FIFO_D = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            tile_en,
  input  logic            joiner_op,
  input  logic [DATA_W:0] coord_in_0,
  input  logic            coord_in_0_valid,
  output logic            coord_in_0_ready,
  input  logic [DATA_W:0] coord_in_1,
  input  logic            coord_in_1_valid,
  output logic            coord_in_1_ready,
  input  logic [DATA_W:0] pos_in_0,
  input  logic            pos_in_0_valid,
  output logic            pos_in_0_ready,
  input  logic [DATA_W:0] pos_in_1,
  input  logic            pos_in_1_valid,
  output logic            pos_in_1_ready,
  output logic [DATA_W:0] coord_out,
  output logic            coord_out_valid,
  input  logic            coord_out_ready,
  output logic [DATA_W:0] pos_out_0,
  output logic            pos_out_0_valid,
  input  logic            pos_out_0_ready,
  output logic [DATA_W:0] pos_out_1,
  output logic            pos_out_1_valid,
  input  logic            pos_out_1_ready
);
  import sam_pkg::*;

  localparam int W = DATA_W + 1;
  localparam logic [W-1:0] MAYBE_WORD = {1'b1, MAYBE_TOKEN};
  localparam logic [W-1:0] DONE_WORD  = {1'b1, DONE_TOKEN};

  logic         live, en;
  logic [W-1:0] c0, c1, p0, p1;
  logic         c0_v, c1_v, p0_v, p1_v;
  logic         c0_rdy, c1_rdy, p0_rdy, p1_rdy;
  logic         oc_rdy, op0_rdy, op1_rdy;
  logic         oc_v, op0_v, op1_v;
  logic [W-1:0] oc_d, op0_d, op1_d;
  logic         avail0, avail1, space, go, is_union;
  logic         pop0, pop1, emit, emit_done;
  join_state_t  state, state_next;

  // Holds every handshake low until the first enabled clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      live <= 1'b0;
    else if (clk_en) live <= 1'b1;
  end

  assign en = tile_en && live;

  reg_fifo #(.WIDTH(W), .DEPTH(FIFO_D)) u_c0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_data(coord_in_0), .in_valid(coord_in_0_valid && en), .in_ready(c0_rdy),
    .out_data(c0), .out_valid(c0_v), .out_ready(pop0));
  reg_fifo #(.WIDTH(W), .DEPTH(FIFO_D)) u_p0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_data(pos_in_0), .in_valid(pos_in_0_valid && en), .in_ready(p0_rdy),
    .out_data(p0), .out_valid(p0_v), .out_ready(pop0));
  reg_fifo #(.WIDTH(W), .DEPTH(FIFO_D)) u_c1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_data(coord_in_1), .in_valid(coord_in_1_valid && en), .in_ready(c1_rdy),
    .out_data(c1), .out_valid(c1_v), .out_ready(pop1));
  reg_fifo #(.WIDTH(W), .DEPTH(FIFO_D)) u_p1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_data(pos_in_1), .in_valid(pos_in_1_valid && en), .in_ready(p1_rdy),
    .out_data(p1), .out_valid(p1_v), .out_ready(pop1));

  assign coord_in_0_ready = en && c0_rdy;
  assign pos_in_0_ready   = en && p0_rdy;
  assign coord_in_1_ready = en && c1_rdy;
  assign pos_in_1_ready   = en && p1_rdy;

  assign avail0   = c0_v && p0_v;
  assign avail1   = c1_v && p1_v;
  assign space    = oc_rdy && op0_rdy && op1_rdy;
  assign go       = en && avail0 && avail1 && space;
  assign is_union = (joiner_op == JOIN_UNION);

  // A one-sided DONE is treated as a stop for popping: the other side drains up to its DONE.
  always_comb begin
    pop0      = 1'b0;
    pop1      = 1'b0;
    emit      = 1'b0;
    emit_done = 1'b0;
    oc_d      = '0;
    op0_d     = '0;
    op1_d     = '0;
    if (go) begin
      if (!c0[DATA_W] && !c1[DATA_W]) begin
        if (c0 == c1) begin
          emit = 1'b1; pop0 = 1'b1; pop1 = 1'b1;
          oc_d = c0; op0_d = p0; op1_d = p1;
        end else if (c0 < c1) begin
          emit = is_union; pop0 = 1'b1;
          oc_d = c0; op0_d = p0; op1_d = MAYBE_WORD;
        end else begin
          emit = is_union; pop1 = 1'b1;
          oc_d = c1; op0_d = MAYBE_WORD; op1_d = p1;
        end
      end else if (!c0[DATA_W]) begin
        emit = is_union; pop0 = 1'b1;
        oc_d = c0; op0_d = p0; op1_d = MAYBE_WORD;
      end else if (!c1[DATA_W]) begin
        emit = is_union; pop1 = 1'b1;
        oc_d = c1; op0_d = MAYBE_WORD; op1_d = p1;
      end else if (is_done(c0) && is_done(c1)) begin
        emit = 1'b1; emit_done = 1'b1; pop0 = 1'b1; pop1 = 1'b1;
        oc_d = DONE_WORD; op0_d = DONE_WORD; op1_d = DONE_WORD;
      end else if (is_done(c0)) begin
        pop1 = 1'b1;
      end else if (is_done(c1)) begin
        pop0 = 1'b1;
      end else begin
        pop0 = 1'b1; pop1 = 1'b1;
        if (is_stop(c0) && is_stop(c1)) begin
          emit  = 1'b1;
          oc_d  = (c0 >= c1) ? c0 : c1;
          op0_d = oc_d;
          op1_d = oc_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= ST_START;
    else if (clk_en) state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!tile_en)                                   state_next = ST_START;
    else if (emit_done)                             state_next = ST_START;
    else if (state == ST_START && avail0 && avail1) state_next = ST_RUN;
  end

  reg_fifo #(.WIDTH(W), .DEPTH(FIFO_D)) u_oc (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_data(oc_d), .in_valid(emit), .in_ready(oc_rdy),
    .out_data(coord_out), .out_valid(oc_v), .out_ready(coord_out_ready && en));
  reg_fifo #(.WIDTH(W), .DEPTH(FIFO_D)) u_op0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_data(op0_d), .in_valid(emit), .in_ready(op0_rdy),
    .out_data(pos_out_0), .out_valid(op0_v), .out_ready(pos_out_0_ready && en));
  reg_fifo #(.WIDTH(W), .DEPTH(FIFO_D)) u_op1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_data(op1_d), .in_valid(emit), .in_ready(op1_rdy),
    .out_data(pos_out_1), .out_valid(op1_v), .out_ready(pos_out_1_ready && en));

  assign coord_out_valid = en && oc_v;
  assign pos_out_0_valid = en && op0_v;
  assign pos_out_1_valid = en && op1_v;

endmodule

// File: tb/tb_intersect_unit.sv
// Scoreboard bench for intersect_unit: directed streams, expected triples queued up front,
// a monitor pops and compares on every output handshake.
module tb_intersect_unit;

  localparam int W = 17;
  localparam logic [W-1:0] S0 = 17'h10000;
  localparam logic [W-1:0] S1 = 17'h10001;
  localparam logic [W-1:0] DN = 17'h10100;
  localparam logic [W-1:0] MB = 17'h10200;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, tile_en = 1'b1, joiner_op = 1'b0;
  logic [W-1:0] coord_in_0 = '0, coord_in_1 = '0, pos_in_0 = '0, pos_in_1 = '0;
  logic coord_in_0_valid = 1'b0, coord_in_1_valid = 1'b0, pos_in_0_valid = 1'b0, pos_in_1_valid = 1'b0;
  logic coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready;
  logic [W-1:0] coord_out, pos_out_0, pos_out_1;
  logic coord_out_valid, pos_out_0_valid, pos_out_1_valid;
  logic coord_out_ready = 1'b1, pos_out_0_ready = 1'b1, pos_out_1_ready = 1'b1;

  int vectors = 0, miscompares = 0, nout = 0;
  logic [W-1:0] q_c0[$], q_p0[$], q_c1[$], q_p1[$];
  logic [3*W-1:0] exp_q[$];
  bit toggle_rdy = 1'b0;

  intersect_unit #(.DATA_W(16), .FIFO_D(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .tile_en(tile_en), .joiner_op(joiner_op),
    .coord_in_0(coord_in_0), .coord_in_0_valid(coord_in_0_valid), .coord_in_0_ready(coord_in_0_ready),
    .coord_in_1(coord_in_1), .coord_in_1_valid(coord_in_1_valid), .coord_in_1_ready(coord_in_1_ready),
    .pos_in_0(pos_in_0), .pos_in_0_valid(pos_in_0_valid), .pos_in_0_ready(pos_in_0_ready),
    .pos_in_1(pos_in_1), .pos_in_1_valid(pos_in_1_valid), .pos_in_1_ready(pos_in_1_ready),
    .coord_out(coord_out), .coord_out_valid(coord_out_valid), .coord_out_ready(coord_out_ready),
    .pos_out_0(pos_out_0), .pos_out_0_valid(pos_out_0_valid), .pos_out_0_ready(pos_out_0_ready),
    .pos_out_1(pos_out_1), .pos_out_1_valid(pos_out_1_valid), .pos_out_1_ready(pos_out_1_ready));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] dv(input int v);
    return {1'b0, v[15:0]};
  endfunction

  task automatic side0(input logic [W-1:0] c, input logic [W-1:0] p);
    q_c0.push_back(c); q_p0.push_back(p);
  endtask
  task automatic side1(input logic [W-1:0] c, input logic [W-1:0] p);
    q_c1.push_back(c); q_p1.push_back(p);
  endtask
  task automatic expect3(input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back({c, a, b});
  endtask

  task automatic load_basic();
    side0(dv(0), dv(0)); side0(dv(2), dv(1)); side0(dv(4), dv(2)); side0(S0, S0); side0(DN, DN);
    side1(dv(2), dv(0)); side1(dv(3), dv(1)); side1(dv(4), dv(2)); side1(S0, S0); side1(DN, DN);
  endtask
  task automatic expect_isect();
    expect3(dv(2), dv(1), dv(0)); expect3(dv(4), dv(2), dv(2)); expect3(S0, S0, S0); expect3(DN, DN, DN);
  endtask
  task automatic expect_union();
    expect3(dv(0), dv(0), MB); expect3(dv(2), dv(1), dv(0)); expect3(dv(3), MB, dv(1));
    expect3(dv(4), dv(2), dv(2)); expect3(S0, S0, S0); expect3(DN, DN, DN);
  endtask
  task automatic load_empty_fiber();
    side0(S0, S0); side0(DN, DN);
    side1(dv(5), dv(0)); side1(S0, S0); side1(DN, DN);
    expect3(S0, S0, S0); expect3(DN, DN, DN);
  endtask

  function automatic int pending();
    return q_c0.size() + q_p0.size() + q_c1.size() + q_p1.size() + exp_q.size();
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(pending()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic flush();
    q_c0.delete(); q_p0.delete(); q_c1.delete(); q_p1.delete(); exp_q.delete();
  endtask

  // Stimulus driver: presents queue heads after the falling edge, pops on accepted transfers.
  initial begin
    bit h0c, h0p, h1c, h1p;
    bit rdy = 1'b1;
    forever begin
      @(negedge clk); #1;
      coord_in_0_valid = (q_c0.size() != 0); coord_in_0 = (q_c0.size() != 0) ? q_c0[0] : '0;
      pos_in_0_valid   = (q_p0.size() != 0); pos_in_0   = (q_p0.size() != 0) ? q_p0[0] : '0;
      coord_in_1_valid = (q_c1.size() != 0); coord_in_1 = (q_c1.size() != 0) ? q_c1[0] : '0;
      pos_in_1_valid   = (q_p1.size() != 0); pos_in_1   = (q_p1.size() != 0) ? q_p1[0] : '0;
      rdy = toggle_rdy ? ~rdy : 1'b1;
      coord_out_ready = rdy; pos_out_0_ready = rdy; pos_out_1_ready = rdy;
      #1;
      h0c = coord_in_0_valid && coord_in_0_ready && clk_en;
      h0p = pos_in_0_valid && pos_in_0_ready && clk_en;
      h1c = coord_in_1_valid && coord_in_1_ready && clk_en;
      h1p = pos_in_1_valid && pos_in_1_ready && clk_en;
      @(posedge clk);
      if (h0c && q_c0.size() != 0) void'(q_c0.pop_front());
      if (h0p && q_p0.size() != 0) void'(q_p0.pop_front());
      if (h1c && q_c1.size() != 0) void'(q_c1.pop_front());
      if (h1p && q_p1.size() != 0) void'(q_p1.pop_front());
    end
  end

  // Monitor: every output handshake is checked against the scoreboard head.
  initial begin
    logic [3*W-1:0] want;
    forever begin
      @(negedge clk); #2;
      if (coord_out_valid && coord_out_ready && clk_en) begin
        nout++;
        check("out_pos_valid", 64'({pos_out_0_valid, pos_out_1_valid}), 64'd3);
        if (exp_q.size() == 0) begin
          check("out_unexpected", 64'({coord_out, pos_out_0, pos_out_1}), 64'd0);
        end else begin
          want = exp_q.pop_front();
          check("out_triple", 64'({coord_out, pos_out_0, pos_out_1}), 64'(want));
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    repeat (2) @(negedge clk); #3;
    check("rst_valid", 64'({coord_out_valid, pos_out_0_valid, pos_out_1_valid}), 64'd0);
    check("rst_ready", 64'({coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}), 64'd0);
    check("rst_data", 64'({coord_out, pos_out_0, pos_out_1}), 64'd0);
    @(negedge clk); #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    joiner_op = 1'b0; load_basic(); expect_isect(); drain("isect", 200);
    joiner_op = 1'b1; load_basic(); expect_union(); drain("union", 200);
    toggle_rdy = 1'b1; load_basic(); expect_union(); drain("union_bp", 300); toggle_rdy = 1'b0;
    joiner_op = 1'b0; load_empty_fiber(); drain("empty_fiber", 200);

    side0(dv(7), dv(3)); side0(S1, S1); side0(DN, DN);
    side1(dv(7), dv(4)); side1(S0, S0); side1(DN, DN);
    expect3(dv(7), dv(3), dv(4)); expect3(S1, S1, S1); expect3(DN, DN, DN);
    drain("stop_levels", 200);

    @(negedge clk); #3 tile_en = 1'b0;
    load_basic();
    repeat (6) begin
      @(negedge clk); #3;
      check("tile_off_ready", 64'({coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}), 64'd0);
      check("tile_off_valid", 64'({coord_out_valid, pos_out_0_valid, pos_out_1_valid}), 64'd0);
    end
    check("tile_off_hold", 64'(pending()), 64'd20);
    expect_isect();
    tile_en = 1'b1;
    drain("tile_on", 200);

    load_basic(); expect_isect();
    base = nout;
    n = 0;
    while (nout < base + 2 && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    check("rst_mid_reached", 64'(nout >= base + 2), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'({coord_out_valid, pos_out_0_valid, pos_out_1_valid}), 64'd0);
    check("rst_mid_ready", 64'({coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}), 64'd0);
    check("rst_mid_data", 64'({coord_out, pos_out_0, pos_out_1}), 64'd0);
    flush();
    @(negedge clk); #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    load_empty_fiber(); drain("after_reset", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
